// File: rtl/spram_stress_engine.sv
// SPRAM traffic generator and checker. It drives LFSR flood traffic or write/read-back verify
// passes into NUM_BANKS banks, and duty-cycle gating gives repeatable power steps.
module spram_stress_engine #(
  parameter int          NUM_BANKS  = 4,
  parameter int          ADDR_WIDTH = 14,
  parameter int          DATA_WIDTH = 16,
  parameter int          DUTY_BITS  = 4,
  parameter logic [31:0] SEED       = 32'hACE1_2468
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            enable,
  input  logic [1:0]                      mode,
  input  logic [DUTY_BITS-1:0]            duty,
  output logic [ADDR_WIDTH-1:0]           ram_address,
  output logic [DATA_WIDTH-1:0]           ram_datain,
  output logic [NUM_BANKS-1:0]            ram_wren,
  output logic [NUM_BANKS-1:0]            ram_chipselect,
  input  logic [NUM_BANKS*DATA_WIDTH-1:0] ram_dataout,
  output logic                            busy,
  output logic                            error_flag,
  output logic [15:0]                     error_count,
  output logic [15:0]                     pass_count,
  output logic                            activity
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WFLOOD = 3'd1,
    S_RFLOOD = 3'd2,
    S_QUIET  = 3'd3,
    S_VWRITE = 3'd4,
    S_VREAD  = 3'd5,
    S_VDRAIN = 3'd6
  } state_t;

  localparam logic [31:0]           TAPS      = 32'h8020_0003;
  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = {ADDR_WIDTH{1'b1}};
  localparam logic [DUTY_BITS-1:0]  DUTY_FULL = {DUTY_BITS{1'b1}};

  // Galois step for x^32+x^22+x^2+x+1, shifting toward bit 0
  function automatic logic [31:0] lfsr_step(input logic [31:0] v);
    lfsr_step = {1'b0, v[31:1]} ^ (v[0] ? TAPS : 32'h0000_0000);
  endfunction

  state_t                  state, next_state;
  logic [DUTY_BITS-1:0]    duty_sh;
  logic [DUTY_BITS-1:0]    phase;
  logic [31:0]             lfsr;
  logic [ADDR_WIDTH-1:0]   addr;
  logic                    exp_valid;
  logic [DATA_WIDTH-1:0]   exp_data;
  logic                    active, flood;
  logic                    cs_on, we_on, step, sweep, reload, launch, pass_done;
  logic [3:0]              miss_n;
  logic [16:0]             err_sum;

  assign active = (duty_sh == DUTY_FULL) || (phase < duty_sh);
  assign flood  = (state == S_WFLOOD) || (state == S_RFLOOD);
  assign busy   = (state != S_IDLE);

  assign ram_chipselect = {NUM_BANKS{cs_on}};
  assign ram_wren       = {NUM_BANKS{we_on}};
  assign ram_address    = !busy ? {ADDR_WIDTH{1'b0}} : (flood ? lfsr[ADDR_WIDTH+15:16] : addr);
  assign ram_datain     = !busy ? {DATA_WIDTH{1'b0}} : lfsr[DATA_WIDTH-1:0];
  assign activity       = busy & (^lfsr);

  // Next-state and per-cycle bus controls; dropping enable idles the bus at once
  always_comb begin
    next_state = state;
    cs_on      = 1'b0;
    we_on      = 1'b0;
    step       = 1'b0;
    sweep      = 1'b0;
    reload     = 1'b0;
    launch     = 1'b0;
    pass_done  = 1'b0;
    case (state)
      S_IDLE: begin
        if (enable) begin
          reload = 1'b1;
          case (mode)
            2'd0:    next_state = S_WFLOOD;
            2'd1:    next_state = S_RFLOOD;
            2'd2:    next_state = S_VWRITE;
            2'd3:    next_state = S_QUIET;
            default: next_state = S_IDLE;
          endcase
        end else begin
          next_state = S_IDLE;
        end
      end
      S_WFLOOD, S_RFLOOD: begin
        if (!enable) begin
          next_state = S_IDLE;
        end else if (active) begin
          cs_on = 1'b1;
          we_on = (state == S_WFLOOD);
          step  = 1'b1;
        end else begin
          cs_on = 1'b0;
        end
      end
      S_QUIET: begin
        if (!enable) next_state = S_IDLE;
        else         next_state = S_QUIET;
      end
      S_VWRITE, S_VREAD: begin
        if (!enable) begin
          next_state = S_IDLE;
        end else if (active) begin
          cs_on  = 1'b1;
          we_on  = (state == S_VWRITE);
          launch = (state == S_VREAD);
          step   = 1'b1;
          sweep  = 1'b1;
          if (addr == ADDR_LAST) begin
            next_state = (state == S_VWRITE) ? S_VREAD : S_VDRAIN;
            reload     = (state == S_VWRITE);
          end else begin
            next_state = state;
          end
        end else begin
          cs_on = 1'b0;
        end
      end
      S_VDRAIN: begin
        if (!enable) begin
          next_state = S_IDLE;
        end else begin
          pass_done  = 1'b1;
          reload     = 1'b1;
          next_state = S_VWRITE;
        end
      end
      default: next_state = S_IDLE;
    endcase
  end

  // Per-bank miscompare count against the expected word, and saturating sum
  always_comb begin
    miss_n = 4'd0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (ram_dataout[b*DATA_WIDTH +: DATA_WIDTH] != exp_data) miss_n = miss_n + 4'd1;
      else                                                     miss_n = miss_n;
    end
    err_sum = {1'b0, error_count} + {13'd0, miss_n};
  end

  // State, pattern generators, read-latency pipeline and result counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      duty_sh     <= {DUTY_BITS{1'b0}};
      phase       <= {DUTY_BITS{1'b0}};
      lfsr        <= SEED;
      addr        <= {ADDR_WIDTH{1'b0}};
      exp_valid   <= 1'b0;
      exp_data    <= {DATA_WIDTH{1'b0}};
      error_flag  <= 1'b0;
      error_count <= 16'h0000;
      pass_count  <= 16'h0000;
    end else begin
      state <= next_state;
      if (!busy && enable) duty_sh <= duty;
      phase <= busy ? phase + DUTY_BITS'(1) : {DUTY_BITS{1'b0}};
      if (reload)    lfsr <= SEED;
      else if (step) lfsr <= lfsr_step(lfsr);
      if (reload)     addr <= {ADDR_WIDTH{1'b0}};
      else if (sweep) addr <= addr + ADDR_WIDTH'(1);
      // Expected word trails the read by one cycle, matching SPRAM read latency
      exp_valid <= launch;
      if (launch) exp_data <= lfsr[DATA_WIDTH-1:0];
      if (exp_valid && enable) begin
        error_count <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
        if (miss_n != 4'd0) error_flag <= 1'b1;
      end
      if (pass_done) pass_count <= pass_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_spram_stress_engine.sv
// Self-checking bench for spram_stress_engine: behavioural SPRAM banks with fault injection,
// a table of verify scenarios, randomized flood/verify runs and multi-cycle corner sequences.
module tb_spram_stress_engine;

  localparam int          NB   = 4;
  localparam int          AW   = 4;
  localparam int          DW   = 16;
  localparam int          DB   = 4;
  localparam logic [31:0] SEED = 32'hACE1_2468;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              enable = 1'b0;
  logic [1:0]        mode = 2'd0;
  logic [DB-1:0]     duty = 4'd0;
  logic [AW-1:0]     ram_address;
  logic [DW-1:0]     ram_datain;
  logic [NB-1:0]     ram_wren, ram_chipselect;
  logic [NB*DW-1:0]  ram_dataout;
  logic              busy, error_flag, activity;
  logic [15:0]       error_count, pass_count;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_err = 0;
  int exp_pass = 0;
  logic exp_flag = 1'b0;

  logic [NB-1:0] f_mask = 4'b0000;
  logic [AW-1:0] f_addr = 4'd0;
  logic          f_all = 1'b0;
  logic [DW-1:0] mem [NB][16];

  typedef struct {
    logic [NB-1:0] mask;
    logic [AW-1:0] addr;
    int            passes;
    int            delta;
  } vec_t;
  vec_t vt [5];

  always #5 clk = ~clk;

  spram_stress_engine #(.NUM_BANKS(NB), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DUTY_BITS(DB), .SEED(SEED)) dut (
    .clk(clk), .reset(reset), .enable(enable), .mode(mode), .duty(duty),
    .ram_address(ram_address), .ram_datain(ram_datain), .ram_wren(ram_wren),
    .ram_chipselect(ram_chipselect), .ram_dataout(ram_dataout), .busy(busy),
    .error_flag(error_flag), .error_count(error_count), .pass_count(pass_count),
    .activity(activity)
  );

  function automatic logic [DW-1:0] flip_of(input int b, input logic [AW-1:0] a);
    if (f_mask[b] && (f_all || a == f_addr)) return f_all ? 16'hFFFF : 16'h0001;
    return 16'h0000;
  endfunction

  // Behavioural SPRAM banks: one-cycle read latency, output held between reads
  always @(posedge clk) begin
    for (int b = 0; b < NB; b++) begin
      if (ram_chipselect[b]) begin
        if (ram_wren[b]) mem[b][ram_address] <= ram_datain;
        else             ram_dataout[b*DW +: DW] <= mem[b][ram_address] ^ flip_of(b, ram_address);
      end
    end
  end

  function automatic logic [31:0] lfsr_next(input logic [31:0] v);
    return v[0] ? ((v >> 1) ^ 32'h8020_0003) : (v >> 1);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add_err(input int delta);
    exp_err = (exp_err + delta > 65535) ? 65535 : exp_err + delta;
    if (delta > 0) exp_flag = 1'b1;
  endtask

  task automatic run_verify(input logic [DB-1:0] d, input int passes, input int delta);
    int cyc;
    logic [15:0] target;
    target = 16'(exp_pass + passes);
    mode = 2'd2; duty = d; enable = 1'b1;
    cyc = 0;
    while (pass_count != target && cyc < passes * 640 + 100) begin
      tick();
      cyc++;
    end
    enable = 1'b0;
    tick();
    exp_pass = int'(target);
    add_err(delta);
    check("verify_pass_count", pass_count, target);
    check("verify_error_count", error_count, exp_err);
    check("verify_error_flag", error_flag, exp_flag);
    check("verify_idle", busy, 1'b0);
  endtask

  task automatic run_flood(input logic [1:0] m, input logic [DB-1:0] d);
    logic [31:0] lf;
    int cs_n;
    int exp_n;
    lf = SEED;
    cs_n = 0;
    exp_n = (m == 2'd3) ? 0 : ((d == 4'hF) ? 32 : 2 * int'(d));
    mode = m; duty = d; enable = 1'b1;
    tick();
    for (int c = 0; c < 32; c++) begin
      @(negedge clk);
      if (ram_chipselect !== 4'h0) begin
        cs_n++;
        check("flood_cs_all", ram_chipselect, 4'hF);
        check("flood_wren", ram_wren, (m == 2'd0) ? 4'hF : 4'h0);
        check("flood_addr", ram_address, lf[AW+15:16]);
        check("flood_data", ram_datain, lf[DW-1:0]);
        lf = lfsr_next(lf);
      end
      tick();
    end
    check("flood_busy", busy, 1'b1);
    check("flood_lfsr_hold", ram_datain, lf[DW-1:0]);
    check("flood_cs_count", cs_n, exp_n);
    enable = 1'b0;
    tick();
    check("flood_idle", busy, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cyc;
    logic [31:0] seed_v;
    logic hit;
    seed_v = SEED;
    vt[0] = '{mask: 4'b0000, addr: 4'd5,  passes: 2, delta: 0};
    vt[1] = '{mask: 4'b0100, addr: 4'd5,  passes: 1, delta: 1};
    vt[2] = '{mask: 4'b1001, addr: 4'd5,  passes: 2, delta: 4};
    vt[3] = '{mask: 4'b1111, addr: 4'd0,  passes: 1, delta: 4};
    vt[4] = '{mask: 4'b0010, addr: 4'd15, passes: 3, delta: 3};

    // Reset state
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    tick();
    check("rst_busy", busy, 1'b0);
    check("rst_cs", ram_chipselect, 4'h0);
    check("rst_wren", ram_wren, 4'h0);
    check("rst_addr", ram_address, 4'h0);
    check("rst_data", ram_datain, 16'h0);
    check("rst_err", error_count, 16'h0);
    check("rst_flag", error_flag, 1'b0);
    check("rst_pass", pass_count, 16'h0);
    check("rst_activity", activity, 1'b0);

    // Exact pass timing: 1 IDLE exit + 16 writes + 16 reads + 1 drain
    mode = 2'd2; duty = 4'hF; enable = 1'b1;
    tick();
    cyc = 1;
    check("entry_addr", ram_address, 4'h0);
    check("entry_cs", ram_chipselect, 4'hF);
    check("entry_wren", ram_wren, 4'hF);
    check("entry_data", ram_datain, seed_v[DW-1:0]);
    while (pass_count != 16'd1 && cyc < 100) begin tick(); cyc++; end
    check("pass1_cycles", cyc, 34);
    cyc = 0;
    while (pass_count != 16'd2 && cyc < 100) begin tick(); cyc++; end
    check("pass2_cycles", cyc, 33);
    check("clean_err", error_count, 16'h0);
    enable = 1'b0;
    tick();
    exp_pass = 2;
    check("clean_idle", busy, 1'b0);

    // Table of verify scenarios with injected read faults
    for (int i = 0; i < 5; i++) begin
      f_mask = vt[i].mask; f_addr = vt[i].addr; f_all = 1'b0;
      run_verify(4'hF, vt[i].passes, vt[i].delta);
    end
    f_mask = 4'b0000;

    // Duty gating
    run_flood(2'd0, 4'd4);
    run_flood(2'd0, 4'd0);
    run_flood(2'd1, 4'hF);
    run_flood(2'd3, 4'hF);

    // Randomized flood and verify runs
    for (int i = 0; i < 6; i++) begin
      logic [1:0] m;
      case ($urandom % 3)
        0:       m = 2'd0;
        1:       m = 2'd1;
        default: m = 2'd3;
      endcase
      run_flood(m, 4'($urandom_range(0, 15)));
    end
    for (int i = 0; i < 4; i++) begin
      int p;
      f_mask = 4'($urandom);
      f_addr = 4'($urandom);
      p = $urandom_range(1, 2);
      run_verify(4'($urandom_range(1, 15)), p, p * $countones(f_mask));
    end

    // Abort at read address 8; the pending compare of address 7 must be discarded
    f_mask = 4'b0010; f_addr = 4'd7; f_all = 1'b0;
    mode = 2'd2; duty = 4'hF; enable = 1'b1;
    hit = 1'b0;
    for (int c = 0; c < 100 && !hit; c++) begin
      @(negedge clk);
      hit = (ram_chipselect == 4'hF) && (ram_wren == 4'h0) && (ram_address == 4'd8);
    end
    check("abort_reached", hit, 1'b1);
    enable = 1'b0;
    #1;
    check("abort_cs", ram_chipselect, 4'h0);
    check("abort_wren", ram_wren, 4'h0);
    tick();
    check("abort_idle", busy, 1'b0);
    tick();
    check("abort_err", error_count, exp_err);
    check("abort_pass", pass_count, exp_pass);
    enable = 1'b1;
    tick();
    check("restart_addr", ram_address, 4'h0);
    check("restart_wren", ram_wren, 4'hF);
    enable = 1'b0;
    tick();
    f_mask = 4'b0000;

    // Saturation: every bank miscompares on every read
    f_mask = 4'hF; f_all = 1'b1;
    run_verify(4'hF, 1100, 1100 * 64);
    check("sat_err", error_count, 16'hFFFF);
    f_mask = 4'h0; f_all = 1'b0;

    // Asynchronous reset mid-VREAD
    mode = 2'd2; duty = 4'hF; enable = 1'b1;
    hit = 1'b0;
    for (int c = 0; c < 100 && !hit; c++) begin
      @(negedge clk);
      hit = (ram_chipselect == 4'hF) && (ram_wren == 4'h0);
    end
    check("vread_reached", hit, 1'b1);
    #2 reset = 1'b1;
    #1;
    check("arst_busy", busy, 1'b0);
    check("arst_cs", ram_chipselect, 4'h0);
    check("arst_addr", ram_address, 4'h0);
    check("arst_data", ram_datain, 16'h0);
    check("arst_err", error_count, 16'h0);
    check("arst_flag", error_flag, 1'b0);
    check("arst_pass", pass_count, 16'h0);
    check("arst_activity", activity, 1'b0);
    enable = 1'b0;
    tick();
    reset = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/spram_stress_engine.md
Name: spram_stress_engine

Overview:
- Parametrised traffic generator and checker for the iCE40UP SPRAM power/stress builds.
- Drives NUM_BANKS SB_SPRAM256KA instances with LFSR-derived address and data patterns.
- Duty-cycle gating gives repeatable power steps. A write/read-back verify mode counts data corruption under thermal and supply stress.
- Sits between the PLL-driven system clock and the SPRAM primitives in the stress-test top level.

Parameters:
- NUM_BANKS, 4, number of SPRAM banks driven (1..4)
- ADDR_WIDTH, 14, SPRAM word address width
- DATA_WIDTH, 16, SPRAM data width (≤32)
- DUTY_BITS, 4, width of the duty-cycle control and phase counter
- SEED, 32'hACE1_2468, LFSR seed; must be non-zero

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- enable  in  1  run request
- mode  in  2  0=WRITE_FLOOD, 1=READ_FLOOD, 2=VERIFY, 3=QUIET
- duty  in  DUTY_BITS  activity duty (see Behaviour)
- ram_address  out  ADDR_WIDTH  shared address to all banks
- ram_datain  out  DATA_WIDTH  shared write data
- ram_wren  out  NUM_BANKS  per-bank write enable
- ram_chipselect  out  NUM_BANKS  per-bank chip select
- ram_dataout  in  NUM_BANKS*DATA_WIDTH  bank read data, bank i at [i*DATA_WIDTH +: DATA_WIDTH]
- busy  out  1  engine not in IDLE
- error_flag  out  1  sticky: any miscompare since reset
- error_count  out  16  miscompare count, saturating
- pass_count  out  16  completed VERIFY passes, wraps
- activity  out  1  XOR-reduce of LFSR; keeps the LFSR from being optimised away

Behaviour:
- Reset: all outputs 0, state IDLE, LFSR=SEED, address and phase counters 0.
- LFSR: 32-bit Galois, polynomial x^32+x^22+x^2+x+1. Advances one step per active cycle only. ram_datain = LFSR[DATA_WIDTH-1:0].
- Duty gating:
  - phase counter of DUTY_BITS free-runs while busy.
  - active = (phase < duty), or duty all-ones → always active.
  - duty=0 → never active.
  - Inactive cycle: chipselect=0, wren=0, address/data held, no compare, no LFSR step.
- IDLE: on enable=1, latch mode and duty into shadow registers, reload LFSR=SEED and address=0, then go to:
  - mode 0 → WFLOOD
  - mode 1 → RFLOOD
  - mode 2 → VWRITE
  - mode 3 → QUIET
- Shadowed mode and duty are not re-sampled until the engine returns to IDLE.
- WFLOOD: each active cycle:
  - all chipselect=1, all wren=1
  - address = LFSR[ADDR_WIDTH+15:16]
  - runs until enable=0
- RFLOOD: as WFLOOD with wren=0; address from LFSR; no compare.
- QUIET: all chipselect/wren 0; busy=1; LFSR frozen.
- VWRITE:
  - Sequential address sweep 0..2^ADDR_WIDTH-1, one word per active cycle, all banks written with the same data.
  - After the last address: LFSR reloaded to SEED, address=0, → VREAD.
- VREAD:
  - Same sweep with wren=0.
  - Expected data regenerated from the LFSR and delayed 1 cycle with a valid bit, matching the SPRAM 1-cycle read latency.
  - A compare happens only on the cycle after an active read.
  - Each bank compares independently; error_count adds the number of mismatching banks that cycle (0..NUM_BANKS), saturating at 16'hFFFF.
  - error_flag sets on any mismatch.
- VDRAIN:
  - 1 cycle after the final read, to perform the last compare.
  - Then pass_count+1 and LFSR reload. Next state: VWRITE if enable=1, else IDLE.
- enable=0 in any non-IDLE state:
  - next cycle → IDLE; chipselect/wren forced 0 that cycle.
  - An in-flight compare is discarded.
  - pass_count is not incremented for a partial pass.
  - error counters retained.
- Error counters and pass_count clear only on reset.
- Address counter wraps naturally at 2^ADDR_WIDTH.
- Async reset mid-pass returns everything to reset values immediately.

Test Plan:
- Bench config: ADDR_WIDTH=4, NUM_BANKS=4, behavioural SPRAM models.
- Reset with enable=0 → busy=0, all chipselect/wren=0, error_count=0, pass_count=0.
- mode=2, duty=all-ones, enable held, models clean → after 16 writes + 16 reads + 1 drain (33 cycles + 1 IDLE exit), pass_count=1, error_count=0; after the second pass pass_count=2.
- mode=2, model bank 2 flips bit 0 at address 5 → each pass error_count +1, error_flag=1; same fault in banks 0 and 3 → +2 per pass.
- mode=0, duty=4, DUTY_BITS=4 → chipselect high exactly 4 of every 16 cycles; duty=0 → chipselect never high, LFSR frozen.
- mode=2, drop enable at read address 8 → IDLE next cycle, pass_count unchanged, no compare on the following cycle; re-enable restarts at write address 0.
- Force 70000 mismatches in mode 2 → error_count saturates at 16'hFFFF; assert reset mid-VREAD → all outputs 0 asynchronously.
